// File: rtl/entropy_encoder.sv
// Converts a zigzag-ordered stream of quantised coefficients into (run, size, value) tokens:
// DC delta coding, AC zero run-length coding with ZRL/EOB, valid/ready on both sides.
module entropy_encoder #(
    parameter int DELTA_ENCODE = 1,
    parameter int BLOCK_LEN    = 64,
    parameter int MAX_RUN      = 15
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [11:0] coeff_in,
    input  logic        sof_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [10:0] value_out,
    output logic [4:0]  run_out,
    output logic [4:0]  size_out,
    output logic        dc_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int IDX_W = $clog2(BLOCK_LEN);
    localparam int RUN_W = IDX_W + 1;

    // Handshake: a coefficient moves when valid_in && ready_out, a token moves when
    // valid_out && ready_in; a presented token and its fields hold until it moves.
    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_ZRL    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RUN_W-1:0]   zrun_q, zrun_d;
    logic [11:0]        last_dc_q, last_dc_d;
    logic [4:0]         hold_size_q, hold_size_d;
    logic [10:0]        hold_value_q, hold_value_d;
    logic               valid_q, valid_d;
    logic [10:0]        value_q, value_d;
    logic [4:0]         run_q, run_d;
    logic [4:0]         size_q, size_d;
    logic               dc_q, dc_d;

    logic               in_fire, out_fire, is_dc, is_last;
    logic [11:0]        dc_pred, enc_v;
    logic [10:0]        enc_abs, enc_mask, enc_value;
    logic [4:0]         enc_size;

    assign ready_out = rst_n_in && (state_q == ST_ACCEPT) && (!valid_q || ready_in);
    assign in_fire   = valid_in && ready_out;
    assign out_fire  = valid_q && ready_in;
    assign is_dc     = (idx_q == '0);
    assign is_last   = (idx_q == IDX_W'(BLOCK_LEN - 1));

    assign valid_out = valid_q;
    assign value_out = value_q;
    assign run_out   = run_q;
    assign size_out  = size_q;
    assign dc_out    = dc_q;

    // Magnitude category and one's-complement value bits of the symbol being coded.
    always_comb begin
        dc_pred = sof_in ? 12'd0 : last_dc_q;
        if (is_dc && (DELTA_ENCODE != 0)) enc_v = coeff_in - dc_pred;
        else                              enc_v = coeff_in;
        enc_abs  = enc_v[11] ? (~enc_v[10:0] + 11'd1) : enc_v[10:0];
        enc_size = 5'd0;
        for (int i = 0; i < 11; i++) begin
            if (enc_abs[i]) enc_size = 5'(i + 1);
        end
        enc_mask  = (11'd1 << enc_size) - 11'd1;
        enc_value = enc_v[11] ? (~enc_abs & enc_mask) : enc_abs;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        zrun_d       = zrun_q;
        last_dc_d    = last_dc_q;
        hold_size_d  = hold_size_q;
        hold_value_d = hold_value_q;
        valid_d      = valid_q;
        value_d      = value_q;
        run_d        = run_q;
        size_d       = size_q;
        dc_d         = dc_q;
        if (out_fire) valid_d = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                if (in_fire) begin
                    idx_d = is_last ? '0 : idx_q + IDX_W'(1);
                    if (is_dc) begin
                        valid_d   = 1'b1;
                        dc_d      = 1'b1;
                        run_d     = 5'd0;
                        size_d    = enc_size;
                        value_d   = enc_value;
                        last_dc_d = coeff_in;
                        zrun_d    = '0;
                    end else if (coeff_in == 12'd0) begin
                        if (is_last) begin
                            valid_d = 1'b1;
                            dc_d    = 1'b0;
                            run_d   = 5'd0;
                            size_d  = 5'd0;
                            value_d = 11'd0;
                            zrun_d  = '0;
                        end else begin
                            zrun_d = zrun_q + RUN_W'(1);
                        end
                    end else if (zrun_q <= RUN_W'(MAX_RUN)) begin
                        valid_d = 1'b1;
                        dc_d    = 1'b0;
                        run_d   = zrun_q[4:0];
                        size_d  = enc_size;
                        value_d = enc_value;
                        zrun_d  = '0;
                    end else begin
                        // Run too long for one token: first ZRL now, coefficient parked.
                        valid_d      = 1'b1;
                        dc_d         = 1'b0;
                        run_d        = 5'(MAX_RUN);
                        size_d       = 5'd0;
                        value_d      = 11'd0;
                        zrun_d       = zrun_q - RUN_W'(MAX_RUN + 1);
                        hold_size_d  = enc_size;
                        hold_value_d = enc_value;
                        state_d      = ST_ZRL;
                    end
                end
            end
            ST_ZRL: begin
                if (out_fire) begin
                    valid_d = 1'b1;
                    dc_d    = 1'b0;
                    if (zrun_q > RUN_W'(MAX_RUN)) begin
                        run_d   = 5'(MAX_RUN);
                        size_d  = 5'd0;
                        value_d = 11'd0;
                        zrun_d  = zrun_q - RUN_W'(MAX_RUN + 1);
                    end else begin
                        run_d   = zrun_q[4:0];
                        size_d  = hold_size_q;
                        value_d = hold_value_q;
                        zrun_d  = '0;
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_ACCEPT;
            idx_q        <= '0;
            zrun_q       <= '0;
            last_dc_q    <= 12'd0;
            hold_size_q  <= 5'd0;
            hold_value_q <= 11'd0;
            valid_q      <= 1'b0;
            value_q      <= 11'd0;
            run_q        <= 5'd0;
            size_q       <= 5'd0;
            dc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            zrun_q       <= zrun_d;
            last_dc_q    <= last_dc_d;
            hold_size_q  <= hold_size_d;
            hold_value_q <= hold_value_d;
            valid_q      <= valid_d;
            value_q      <= value_d;
            run_q        <= run_d;
            size_q       <= size_d;
            dc_q         <= dc_d;
        end
    end

endmodule

// File: tb/tb_entropy_encoder.sv
// Directed bench for entropy_encoder: blocks are streamed in, every handshaken token is logged
// and compared against hand-computed (dc, run, size, value) sequences.
module tb_entropy_encoder;

    logic        clk_in;
    logic        rst_n_in;
    logic [11:0] coeff_in;
    logic        sof_in;
    logic        valid_in;
    logic        ready_out;
    logic [10:0] value_out;
    logic [4:0]  run_out;
    logic [4:0]  size_out;
    logic        dc_out;
    logic        valid_out;
    logic        ready_in;

    int tests_run;
    int tests_failed;
    int low_cnt;
    logic low_cnt_en;

    logic [21:0] tok_q[$];
    logic [21:0] exp_q[$];
    logic [11:0] blk[64];

    entropy_encoder dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .coeff_in (coeff_in),
        .sof_in   (sof_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .value_out(value_out),
        .run_out  (run_out),
        .size_out (size_out),
        .dc_out   (dc_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Token log: {dc, run, size, value} of every completed output handshake.
    always @(posedge clk_in) begin
        if (rst_n_in && valid_out && ready_in)
            tok_q.push_back({dc_out, run_out, size_out, value_out});
    end

    always @(negedge clk_in) begin
        if (low_cnt_en && !ready_out) low_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] tok(input logic dc, input int run, input int size, input int val);
        return {dc, 5'(run), 5'(size), 11'(val)};
    endfunction

    task automatic send(input logic [11:0] c, input logic s);
        int n;
        @(negedge clk_in);
        coeff_in = c;
        sof_in   = s;
        valid_in = 1'b1;
        #1;
        n = 0;
        while (!ready_out && n < 64) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (!ready_out) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout ready_out=%b required 1", ready_out);
        end
        @(posedge clk_in);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 12'd0;
    endtask

    task automatic drain();
        @(negedge clk_in);
        valid_in = 1'b0;
        sof_in   = 1'b0;
        ready_in = 1'b1;
        repeat (8) @(negedge clk_in);
    endtask

    task automatic send_blk(input logic s);
        for (int i = 0; i < 64; i++) send(blk[i], (i == 0) ? s : 1'b0);
        drain();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        coeff_in = 12'd0;
        ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        valid_in = 1'b1;
        #1;
        tests_run++;
        if (ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready got %b required 0", ready_out);
        end
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b required 0", valid_out);
        end
        tests_run++;
        if ({dc_out, run_out, size_out, value_out} !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_fields got %h required 0", {dc_out, run_out, size_out, value_out});
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_dc_eob();
        logic [21:0] got;
        tok_q.delete();
        clear_blk();
        blk[0] = 12'd5;
        send_blk(1'b1);
        exp_q = '{tok(1, 0, 3, 5), tok(0, 0, 0, 0)};
        tests_run++;
        if (tok_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL dc_eob_count got %0d required %0d", tok_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : 22'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL dc_eob tok%0d got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_dc_delta();
        logic [21:0] got;
        // Previous DC was 5: 2 - 5 = -3 -> size 2, value 0b00.
        tok_q.delete();
        clear_blk();
        blk[0] = 12'd2;
        send_blk(1'b0);
        got = (tok_q.size() > 0) ? tok_q[0] : 22'bx;
        tests_run++;
        if (got !== tok(1, 0, 2, 0)) begin
            tests_failed++;
            $display("FAIL dc_delta_neg got %h required %h", got, tok(1, 0, 2, 0));
        end
        tests_run++;
        if (tok_q.size() != 2) begin
            tests_failed++;
            $display("FAIL dc_delta_count got %0d required 2", tok_q.size());
        end
        // Start of frame clears the predictor: 2 - 0 -> size 2, value 0b10.
        tok_q.delete();
        send_blk(1'b1);
        got = (tok_q.size() > 0) ? tok_q[0] : 22'bx;
        tests_run++;
        if (got !== tok(1, 0, 2, 2)) begin
            tests_failed++;
            $display("FAIL dc_sof got %h required %h", got, tok(1, 0, 2, 2));
        end
    endtask

    task automatic test_ac_run();
        logic [21:0] got;
        tok_q.delete();
        clear_blk();
        blk[3] = 12'hFFF;
        send_blk(1'b1);
        blk[3] = 12'd1000;
        send_blk(1'b1);
        exp_q = '{tok(1, 0, 0, 0), tok(0, 2, 1, 0), tok(0, 0, 0, 0),
                  tok(1, 0, 0, 0), tok(0, 2, 10, 1000), tok(0, 0, 0, 0)};
        tests_run++;
        if (tok_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL ac_run_count got %0d required %0d", tok_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : 22'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL ac_run tok%0d got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_zrl();
        logic [21:0] got;
        int lows[3];
        tok_q.delete();
        // 20 zeros then +7; 40 zeros then -2; 62 zeros then +3 at the last index.
        clear_blk();
        blk[21] = 12'd7;
        low_cnt = 0;
        low_cnt_en = 1'b1;
        send_blk(1'b1);
        lows[0] = low_cnt;
        clear_blk();
        blk[41] = 12'hFFE;
        low_cnt = 0;
        send_blk(1'b1);
        lows[1] = low_cnt;
        clear_blk();
        blk[63] = 12'd3;
        low_cnt = 0;
        send_blk(1'b1);
        lows[2] = low_cnt;
        low_cnt_en = 1'b0;
        exp_q = '{tok(1, 0, 0, 0), tok(0, 15, 0, 0), tok(0, 4, 3, 7), tok(0, 0, 0, 0),
                  tok(1, 0, 0, 0), tok(0, 15, 0, 0), tok(0, 15, 0, 0), tok(0, 8, 2, 1),
                  tok(0, 0, 0, 0),
                  tok(1, 0, 0, 0), tok(0, 15, 0, 0), tok(0, 15, 0, 0), tok(0, 15, 0, 0),
                  tok(0, 14, 2, 3)};
        tests_run++;
        if (tok_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL zrl_count got %0d required %0d", tok_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : 22'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL zrl tok%0d got %h required %h", i, got, exp_q[i]);
            end
        end
        for (int b = 0; b < 3; b++) begin
            tests_run++;
            if (lows[b] != b + 1) begin
                tests_failed++;
                $display("FAIL zrl_ready_low blk%0d got %0d cycles required %0d", b, lows[b], b + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] got;
        tok_q.delete();
        ready_in = 1'b0;
        send(12'd4, 1'b1);
        @(negedge clk_in);
        coeff_in = 12'd1;
        sof_in   = 1'b0;
        valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if ({valid_out, dc_out, run_out, size_out, value_out} !== {1'b1, tok(1, 0, 3, 4)}) begin
                tests_failed++;
                $display("FAIL bp_hold cyc%0d got %h required %h", k,
                         {valid_out, dc_out, run_out, size_out, value_out}, {1'b1, tok(1, 0, 3, 4)});
            end
            tests_run++;
            if (ready_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_ready cyc%0d got %b required 0", k, ready_out);
            end
            @(negedge clk_in);
        end
        ready_in = 1'b1;
        #1;
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got %b required 1", ready_out);
        end
        @(posedge clk_in);
        send(12'hFFB, 1'b0);
        for (int i = 3; i < 64; i++) send(12'd0, 1'b0);
        drain();
        exp_q = '{tok(1, 0, 3, 4), tok(0, 0, 1, 1), tok(0, 0, 3, 2), tok(0, 0, 0, 0)};
        tests_run++;
        if (tok_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count got %0d required %0d", tok_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : 22'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp tok%0d got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] got;
        send(12'd9, 1'b1);
        for (int i = 1; i < 30; i++) send(12'd0, 1'b0);
        ready_in = 1'b0;
        send(12'd5, 1'b0);
        @(negedge clk_in);
        #1;
        tests_run++;
        if (valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pending got %b required 1", valid_out);
        end
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        #1;
        tests_run++;
        if (valid_out !== 1'b0 || run_out !== 5'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_drop valid=%b run=%0d required 0 0", valid_out, run_out);
        end
        tests_run++;
        if (ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ready got %b required 0", ready_out);
        end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        ready_in = 1'b1;
        tok_q.delete();
        clear_blk();
        blk[0] = 12'd6;
        send_blk(1'b0);
        exp_q = '{tok(1, 0, 3, 6), tok(0, 0, 0, 0)};
        tests_run++;
        if (tok_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rst_mid_count got %0d required %0d", tok_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : 22'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rst_mid tok%0d got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        low_cnt      = 0;
        low_cnt_en   = 1'b0;
        test_reset();
        test_dc_eob();
        test_dc_delta();
        test_ac_run();
        test_zrl();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
